matrix_result_axis_serializer: RTL and testbench

Serializes one wide matrix-result word, a packed vector of NUM_ELEMS signed elements, into a burst of narrow AXI-Stream beats. Each beat carries ELEMS_PER_BEAT elements, and the final beat of each word is flagged with m_axi_last. The block sits downstream of the MatrixAdd AXI-Stream wrappers: its slave port takes their wide m_axi_data output, and its master port drives a narrow DMA or FIFO interface.

---
 rtl/matrix_result_axis_serializer.sv | 90 +++++++++
 tb/tb_matrix_result_axis_serializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_axis_serializer.sv
// matrix_result_axis_serializer: splits one wide word of signed elements into a burst
// of narrow AXI-Stream beats, flagging the final beat with m_axi_last.
module matrix_result_axis_serializer #(
  parameter  int ELEM_WIDTH     = 17,
  parameter  int NUM_ELEMS      = 120,
  parameter  int ELEMS_PER_BEAT = 4,
  localparam int IN_WIDTH       = NUM_ELEMS * ELEM_WIDTH,
  localparam int BEAT_WIDTH     = ELEMS_PER_BEAT * ELEM_WIDTH,
  localparam int BEATS          = (NUM_ELEMS + ELEMS_PER_BEAT - 1) / ELEMS_PER_BEAT
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [IN_WIDTH-1:0]   s_axi_data,
  input  logic                  s_axi_valid,
  output logic                  s_axi_ready,
  output logic [BEAT_WIDTH-1:0] m_axi_data,
  output logic                  m_axi_valid,
  input  logic                  m_axi_ready,
  output logic                  m_axi_last,
  output logic                  busy
);
  localparam int SR_WIDTH = BEATS * BEAT_WIDTH;
  localparam int IDX_W = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
  typedef enum logic {IDLE, SEND} state_e;
  state_e state_q, state_d;
  logic [SR_WIDTH-1:0] sr_q, sr_d, cap, sr_next;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BEAT_WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d, sready_q, sready_d;
  // left-aligned so short final beats get zero padding in their low slots
  assign cap = SR_WIDTH'(s_axi_data) << (SR_WIDTH - IN_WIDTH);
  assign sr_next = sr_q << BEAT_WIDTH;
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    idx_d = idx_q;
    data_d = data_q;
    valid_d = valid_q;
    last_d = last_q;
    sready_d = sready_q;
    if (state_q == IDLE) begin
      if (s_axi_valid) begin
        state_d = SEND;
        sr_d = cap;
        idx_d = '0;
        data_d = cap[SR_WIDTH-1 -: BEAT_WIDTH];
        valid_d = 1'b1;
        last_d = (BEATS == 1);
        sready_d = 1'b0;
      end
    end else if (valid_q && m_axi_ready) begin
      if (idx_q == LAST_IDX) begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d = 1'b0;
        sready_d = 1'b1;
      end else begin
        sr_d = sr_next;
        data_d = sr_next[SR_WIDTH-1 -: BEAT_WIDTH];
        idx_d = idx_q + 1'b1;
        last_d = (idx_q + 1'b1 == LAST_IDX);
      end
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      sr_q <= '0;
      idx_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      sready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      idx_q <= idx_d;
      data_q <= data_d;
      valid_q <= valid_d;
      last_q <= last_d;
      sready_q <= sready_d;
    end
  end
  assign s_axi_ready = sready_q;
  assign m_axi_data = data_q;
  assign m_axi_valid = valid_q;
  assign m_axi_last = last_q;
  assign busy = (state_q == SEND);
endmodule

// File: tb/tb_matrix_result_axis_serializer.sv
// tb_matrix_result_axis_serializer: directed scoreboard bench over default,
// padded (10 elems) and single-beat (4 elems) configurations.
module tb_matrix_result_axis_serializer;
  localparam int W0 = 120 * 17;
  localparam int W2 = 10 * 17;
  localparam int W3 = 4 * 17;
  typedef struct {logic [67:0] d; logic l;} beat_t;
  logic clk = 1'b0, aresetn;
  always #5 clk = ~clk;
  logic [W0-1:0] s_data0;
  logic [W2-1:0] s_data2;
  logic [W3-1:0] s_data3;
  logic s_valid0, s_valid2, s_valid3, s_ready0, s_ready2, s_ready3;
  logic m_valid0, m_valid2, m_valid3, m_ready0, m_ready2, m_ready3;
  logic m_last0, m_last2, m_last3, busy0, busy2, busy3;
  logic [67:0] m_data0, m_data2, m_data3;
  int asserts = 0, fails = 0;
  bit bp = 0;
  beat_t sb0[$], sb2[$], sb3[$];
  logic [16:0] el[120];

  matrix_result_axis_serializer dut0 (
    .aclk(clk), .aresetn(aresetn), .s_axi_data(s_data0), .s_axi_valid(s_valid0),
    .s_axi_ready(s_ready0), .m_axi_data(m_data0), .m_axi_valid(m_valid0),
    .m_axi_ready(m_ready0), .m_axi_last(m_last0), .busy(busy0));
  matrix_result_axis_serializer #(.NUM_ELEMS(10)) dut2 (
    .aclk(clk), .aresetn(aresetn), .s_axi_data(s_data2), .s_axi_valid(s_valid2),
    .s_axi_ready(s_ready2), .m_axi_data(m_data2), .m_axi_valid(m_valid2),
    .m_axi_ready(m_ready2), .m_axi_last(m_last2), .busy(busy2));
  matrix_result_axis_serializer #(.NUM_ELEMS(4)) dut3 (
    .aclk(clk), .aresetn(aresetn), .s_axi_data(s_data3), .s_axi_valid(s_valid3),
    .s_axi_ready(s_ready3), .m_axi_data(m_data3), .m_axi_valid(m_valid3),
    .m_axi_ready(m_ready3), .m_axi_last(m_last3), .busy(busy3));

  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
    asserts++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_chk(input string tag, inout beat_t q[$], input logic [67:0] d, input logic l);
    beat_t e;
    if (q.size() == 0) begin
      chk({tag, "_unexpected_beat"}, 68'd1, 68'd0);
    end else begin
      e = q.pop_front();
      chk({tag, "_data"}, d, e.d);
      chk({tag, "_last"}, 68'(l), 68'(e.l));
    end
  endtask

  bit stall = 0;
  logic [67:0] prev_d;
  logic prev_l;
  always @(negedge clk) begin
    if (!aresetn) stall = 0;
    else begin
      if (stall) begin
        chk("stall_data", m_data0, prev_d);
        chk("stall_last", 68'(m_last0), 68'(prev_l));
        chk("stall_valid", 68'(m_valid0), 68'd1);
      end
      if (m_valid0 && m_ready0) pop_chk("main", sb0, m_data0, m_last0);
      stall = m_valid0 && !m_ready0;
      prev_d = m_data0;
      prev_l = m_last0;
    end
  end
  always @(negedge clk) if (aresetn && m_valid2 && m_ready2) pop_chk("pad", sb2, m_data2, m_last2);
  always @(negedge clk) if (aresetn && m_valid3 && m_ready3) pop_chk("single", sb3, m_data3, m_last3);

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_main();
    logic [67:0] b;
    s_data0 = '0;
    for (int i = 0; i < 120; i++) s_data0 = {s_data0[W0-18:0], el[i]};
    for (int k = 0; k < 30; k++) begin
      b = '0;
      for (int j = 0; j < 4; j++) b = {b[50:0], el[4*k+j]};
      sb0.push_back('{b, k == 29});
    end
  endtask

  task automatic wait_idle0(input int budget);
    int n = 0;
    while (!(sb0.size() == 0 && s_ready0 && !m_valid0) && n < budget) begin
      m_ready0 = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    chk("idle_within_budget", 68'(n < budget), 68'd1);
    m_ready0 = 1'b1;
  endtask

  task automatic reset_values();
    chk("rst_s_ready", 68'(s_ready0), 68'd1);
    chk("rst_m_valid", 68'(m_valid0), 68'd0);
    chk("rst_m_last", 68'(m_last0), 68'd0);
    chk("rst_m_data", m_data0, 68'd0);
    chk("rst_busy", 68'(busy0), 68'd0);
  endtask

  initial begin
    int n;
    logic [67:0] b, w;
    aresetn = 1'b0;
    {s_valid0, s_valid2, s_valid3} = '0;
    {m_ready0, m_ready2, m_ready3} = '1;
    s_data0 = '0;
    s_data2 = '0;
    s_data3 = '0;
    repeat (3) step();
    reset_values();
    aresetn = 1'b1;
    step();
    // reset mid-word: partial word is dropped and nothing follows until a new word
    for (int i = 0; i < 120; i++) el[i] = 17'(i + 100);
    load_main();
    s_valid0 = 1'b1;
    step();
    s_valid0 = 1'b0;
    repeat (5) step();
    chk("busy_mid_word", 68'(busy0), 68'd1);
    aresetn = 1'b0;
    #1;
    reset_values();
    sb0.delete();
    step();
    aresetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("no_beat_after_reset", 68'(m_valid0), 68'd0);
    end
    // nominal ramp
    for (int i = 0; i < 120; i++) el[i] = 17'(i);
    load_main();
    s_valid0 = 1'b1;
    step();
    s_valid0 = 1'b0;
    chk("first_beat_valid", 68'(m_valid0), 68'd1);
    chk("first_beat_data", m_data0, {17'd0, 17'd1, 17'd2, 17'd3});
    chk("capture_busy", 68'(busy0), 68'd1);
    n = 0;
    while (!s_ready0 && n < 100) begin
      step();
      n++;
    end
    chk("ready_low_cycles", 68'(n), 68'd30);
    chk("nominal_all_beats", 68'(sb0.size()), 68'd0);
    // random data under backpressure
    for (int i = 0; i < 120; i++) el[i] = 17'($urandom_range(0, 17'h1FFFF));
    load_main();
    bp = 1;
    s_valid0 = 1'b1;
    step();
    s_valid0 = 1'b0;
    wait_idle0(2000);
    bp = 0;
    chk("bp_all_beats", 68'(sb0.size()), 68'd0);
    // back-to-back: W1 pending while W0 drains
    for (int i = 0; i < 120; i++) el[i] = 17'(i * 7 + 5);
    load_main();
    s_valid0 = 1'b1;
    step();
    for (int i = 0; i < 120; i++) el[i] = 17'h1FFFF;
    load_main();
    n = 0;
    while (!s_ready0 && n < 100) begin
      step();
      n++;
    end
    chk("b2b_w0_cycles", 68'(n), 68'd30);
    step();
    chk("w1_captured_s_ready", 68'(s_ready0), 68'd0);
    chk("w1_captured_valid", 68'(m_valid0), 68'd1);
    chk("w1_first_beat", m_data0, {4{17'h1FFFF}});
    s_valid0 = 1'b0;
    wait_idle0(200);
    chk("b2b_all_beats", 68'(sb0.size()), 68'd0);
    // padding: 10 elements in 4-wide beats
    for (int i = 0; i < 10; i++) s_data2 = {s_data2[W2-18:0], 17'(i + 1)};
    for (int k = 0; k < 3; k++) begin
      b = '0;
      for (int j = 0; j < 4; j++) b = {b[50:0], (4*k+j < 10) ? 17'(4*k+j+1) : 17'd0};
      sb2.push_back('{b, k == 2});
    end
    s_valid2 = 1'b1;
    step();
    s_valid2 = 1'b0;
    n = 0;
    while (!s_ready2 && n < 100) begin
      if (n == 2) chk("pad_beat2", m_data2, {17'h9, 17'hA, 17'd0, 17'd0});
      step();
      n++;
    end
    chk("pad_cycles", 68'(n), 68'd3);
    chk("pad_all_beats", 68'(sb2.size()), 68'd0);
    // single-beat words under continuous traffic
    w = {4'($urandom), $urandom, $urandom};
    s_data3 = w;
    sb3.push_back('{w, 1'b1});
    s_valid3 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("single_s_ready", 68'(s_ready3), 68'(k % 2));
      if (k % 2 == 0) begin
        if (k < 6) begin
          w = {4'($urandom), $urandom, $urandom};
          s_data3 = w;
          sb3.push_back('{w, 1'b1});
        end else s_valid3 = 1'b0;
      end
    end
    step();
    chk("single_all_beats", 68'(sb3.size()), 68'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
